// File: rtl/mem_wb_pkg.sv
// Shared widths and FSM state type for the dual-lane MEM/WB stage.
package mem_wb_pkg;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 5;
  localparam int DMEM_DEPTH = 256;
  localparam int ADDR_W     = $clog2(DMEM_DEPTH);

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;
endpackage

// File: rtl/data_mem.sv
// Single-ported byte memory: combinational read, write on the rising clock edge.
module data_mem
  import mem_wb_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset so stored data survives a pipeline reset.
  logic [DATA_W-1:0] mem [DMEM_DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Dual-lane MEM/WB stage sharing one data-memory port; a two-lane memory
// conflict is split over two cycles, lane 1 first, with a one-cycle stall.
module mem_wb_stage
  import mem_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     alu_result_1,
  input  logic [DATA_W-1:0]     alu_result_2,
  input  logic [DATA_W-1:0]     write_data_1,
  input  logic [DATA_W-1:0]     write_data_2,
  input  logic [REG_ADDR_W-1:0] rd_1,
  input  logic [REG_ADDR_W-1:0] rd_2,
  input  logic                  mem_read_1,
  input  logic                  mem_read_2,
  input  logic                  mem_write_1,
  input  logic                  mem_write_2,
  input  logic                  mem_to_reg_1,
  input  logic                  mem_to_reg_2,
  input  logic                  reg_write_1,
  input  logic                  reg_write_2,
  output logic                  stall,
  output logic [DATA_W-1:0]     wb_data_1,
  output logic [DATA_W-1:0]     wb_data_2,
  output logic [REG_ADDR_W-1:0] wb_rd_1,
  output logic [REG_ADDR_W-1:0] wb_rd_2,
  output logic                  wb_reg_write_1,
  output logic                  wb_reg_write_2
);

  state_t state, state_next;

  logic active_1, active_2, conflict, use_lane_2;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] lane_data_1, lane_data_2;

  logic [DATA_W-1:0]     hold_data;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic                  hold_reg_write;

  assign active_1 = mem_read_1 | mem_write_1;
  assign active_2 = mem_read_2 | mem_write_2;
  assign conflict = (state == IDLE) && active_1 && active_2;
  assign stall    = conflict;

  always_comb begin
    state_next = IDLE;
    use_lane_2 = 1'b0;
    case (state)
      IDLE: begin
        use_lane_2 = active_2 && !active_1;
        if (conflict) state_next = SECOND;
      end
      SECOND: begin
        use_lane_2 = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        use_lane_2 = 1'b0;
      end
    endcase
  end

  // Reset gates the write so an abandoned lane-2 access never lands.
  assign mem_addr  = use_lane_2 ? alu_result_2 : alu_result_1;
  assign mem_wdata = use_lane_2 ? write_data_2 : write_data_1;
  assign mem_we    = !reset && (use_lane_2 ? mem_write_2 : mem_write_1);

  data_mem u_data_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .we    (mem_we),
    .rdata (mem_rdata)
  );

  assign lane_data_1 = mem_to_reg_1 ? mem_rdata : alu_result_1;
  assign lane_data_2 = mem_to_reg_2 ? mem_rdata : alu_result_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wb_data_1      <= '0;
      wb_data_2      <= '0;
      wb_rd_1        <= '0;
      wb_rd_2        <= '0;
      wb_reg_write_1 <= 1'b0;
      wb_reg_write_2 <= 1'b0;
      hold_data      <= '0;
      hold_rd        <= '0;
      hold_reg_write <= 1'b0;
    end else begin
      state <= state_next;
      if (conflict) begin
        hold_data      <= lane_data_1;
        hold_rd        <= rd_1;
        hold_reg_write <= reg_write_1;
        wb_data_1      <= '0;
        wb_data_2      <= '0;
        wb_rd_1        <= '0;
        wb_rd_2        <= '0;
        wb_reg_write_1 <= 1'b0;
        wb_reg_write_2 <= 1'b0;
      end else if (state == SECOND) begin
        wb_data_1      <= hold_data;
        wb_rd_1        <= hold_rd;
        wb_reg_write_1 <= hold_reg_write;
        wb_data_2      <= lane_data_2;
        wb_rd_2        <= rd_2;
        wb_reg_write_2 <= reg_write_2;
      end else begin
        wb_data_1      <= lane_data_1;
        wb_rd_1        <= rd_1;
        wb_reg_write_1 <= reg_write_1;
        wb_data_2      <= lane_data_2;
        wb_rd_2        <= rd_2;
        wb_reg_write_2 <= reg_write_2;
      end
    end
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: alu_result_1 / alu_result_2  input  8  per-lane ALU result; doubles as data-memory byte address.
REQ-004 SHALL have: write_data_1 / write_data_2  input  8  per-lane store data.
REQ-005 SHALL have: rd_1 / rd_2  input  5  per-lane destination register.
REQ-006 SHALL have: mem_read_1 / mem_read_2, mem_write_1 / mem_write_2  input  1  per-lane load/store request.
REQ-007 SHALL have: mem_to_reg_1 / mem_to_reg_2, reg_write_1 / reg_write_2  input  1  per-lane writeback controls.
REQ-008 SHALL have: stall  output  1  combinational; upstream EX/MEM register holds its contents while high.
REQ-009 SHALL have: wb_data_1 / wb_data_2  output  8  registered writeback data.
REQ-010 SHALL have: wb_rd_1 / wb_rd_2  output  5  registered destination register.
REQ-011 SHALL have: wb_reg_write_1 / wb_reg_write_2  output  1  registered writeback enable.

Function
REQ-012 Data memory SHALL be 256x8, single-ported, with asynchronous read and write on the rising clk edge.
REQ-013 A lane SHALL be memory-active when mem_read or mem_write is 1; if both are 1, the lane SHALL write, and its read data SHALL be the pre-write byte.
REQ-014 wb_data_N SHALL equal the memory read data when mem_to_reg_N=1, and alu_result_N otherwise.
REQ-015 The FSM SHALL have states IDLE and SECOND.
REQ-016 In IDLE with at most one lane memory-active: stall=0, that lane SHALL use the port, both lanes' wb_* SHALL be registered at the edge (latency 1 cycle), and the state SHALL stay IDLE.
REQ-017 In IDLE with both lanes memory-active (conflict):
  - stall SHALL be 1;
  - lane 1 SHALL access memory, and its wb_data SHALL be captured into a hold register;
  - wb_reg_write_1 and wb_reg_write_2 SHALL be registered as 0 (bubble);
  - the next state SHALL be SECOND.
REQ-018 In SECOND:
  - stall SHALL be 0;
  - lane 2 SHALL access memory using the held inputs;
  - lane 1 wb_* SHALL be registered from the hold register and lane 2 wb_* from live values;
  - the next state SHALL be IDLE.
REQ-019 Same-address ordering in a conflict SHALL be lane 1 before lane 2: a lane-2 load sees the lane-1 store, and on a double store lane 2 wins.
REQ-020 Lanes with no memory activity SHALL never cause stall.
REQ-021 Address arithmetic SHALL be none; the 8-bit alu_result SHALL be used directly, so 0xFF is a valid address and there is no wrap logic.

Reset
REQ-022 On reset:
  - state SHALL go to IDLE;
  - stall SHALL be 0 from the next cycle;
  - all wb_* outputs and the hold register SHALL be 0.
REQ-023 Reset SHALL NOT clear data memory contents.
REQ-024 Reset asserted in SECOND SHALL abandon the lane-2 access with no write.
REQ-025 A lane-1 store already committed before reset SHALL persist.
REQ-026 Reset SHALL take priority over any memory write in the same cycle.

Structure
REQ-027 A shared package SHALL hold DATA_W=8, REG_ADDR_W=5, DMEM_DEPTH=256 and the state enum {IDLE, SECOND}.
REQ-028 The memory array SHALL be a sub-module data_mem (addr, wdata, we, rdata, clk); the FSM, arbitration mux and MEM/WB registers SHALL reside in mem_wb_stage.

Verification
REQ-029 The bench SHALL cover: reset, then lane 1 alu=0x10, mem_to_reg=0, reg_write=1, rd=3 -> next cycle wb_data_1=0x10, wb_rd_1=3, wb_reg_write_1=1, stall=0.
REQ-030 The bench SHALL cover: lane 1 store 0xAB to 0x20; next cycle lane 2 load 0x20 with mem_to_reg=1, rd=5 -> wb_data_2=0xAB, wb_rd_2=5, no stall.
REQ-031 The bench SHALL cover: same cycle lane 1 store 0x55 to 0x40 and lane 2 load 0x40 -> stall=1 for one cycle, then bubble; the cycle after, wb_data_2=0x55 and stall=0.
REQ-032 The bench SHALL cover: double store to 0xFF, lane 1 0x11 and lane 2 0x22 -> a later load of 0xFF returns 0x22.
REQ-033 The bench SHALL cover: a conflict with reset asserted in SECOND (lane 2 store 0x77 to 0x30, 0x30 previously 0x00) -> wb_* all 0, IDLE, and 0x30 still reads 0x00.
REQ-034 The bench SHALL cover: both lanes ALU-only with reg_write=1 for 10 back-to-back cycles -> stall never asserts and both lanes produce a result every cycle.
